score_bcd_keeper: RTL and testbench

Score and attempt bookkeeping stage that sits directly upstream of the seven-segment display multiplexer. It accepts shot results over a valid/ready handshake, keeps a two-digit BCD made-points score and a two-digit BCD attempt count, and drives the four digit nibbles the multiplexer displays. It also generates the ~4 kHz single-cycle scan pulse that advances the multiplexer's digit select.

---
 rtl/score_bcd_keeper.sv | 134 +++++++++++++
 tb/tb_score_bcd_keeper.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/score_bcd_keeper.sv
// rtl/score_bcd_keeper.sv - shot score/attempt BCD keeper with scan pulse; optional SCORE_BLANK_EN leading-zero blanking
module score_bcd_keeper #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 4_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       add_valid,
    input  logic [1:0] add_pts,
    output logic       add_ready,
    input  logic       clear,
    output logic       scan_en,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic       busy,
    output logic       overflow
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        INC  = 1'b1
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [3:0]       s1, s0, a1, a0;
    logic [1:0]       rem;
    logic             ovf_q;
    logic [DIV_W-1:0] div_cnt;
    logic             take;
    logic             score_max;
    logic             att_max;

    assign add_ready = (state == IDLE) && !clear;
    assign take      = add_valid && add_ready;
    assign busy      = (state == INC);
    assign overflow  = ovf_q;
    assign score_max = (s1 == 4'd9) && (s0 == 4'd9);
    assign att_max   = (a1 == 4'd9) && (a0 == 4'd9);
    assign scan_en   = (div_cnt == DIV_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: a non-zero shot enters INC, the last remaining point returns to IDLE
    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (take && (add_pts != 2'd0)) next_state = INC;
                INC:     if (rem == 2'd1) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Score, attempts, remaining points and sticky overflow
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            s1    <= 4'd0;
            s0    <= 4'd0;
            a1    <= 4'd0;
            a0    <= 4'd0;
            rem   <= 2'd0;
            ovf_q <= 1'b0;
        end else begin
            if (take) begin
                if (!att_max) begin
                    if (a0 == 4'd9) begin
                        a0 <= 4'd0;
                        a1 <= a1 + 4'd1;
                    end else begin
                        a0 <= a0 + 4'd1;
                    end
                end
                if (add_pts != 2'd0) begin
                    rem <= add_pts;
                end
            end
            if (state == INC) begin
                if (!score_max) begin
                    if (s0 == 4'd9) begin
                        s0 <= 4'd0;
                        s1 <= s1 + 4'd1;
                    end else begin
                        s0 <= s0 + 4'd1;
                    end
                end else begin
                    ovf_q <= 1'b1;
                end
                rem <= rem - 2'd1;
            end
        end
    end

    // Free-running scan divider; clear deliberately leaves it alone
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Digit drive; tens digits optionally blanked with the encoder's blank code
    always_comb begin
        d2 = a0;
        d0 = s0;
`ifdef SCORE_BLANK_EN
        d3 = (a1 == 4'd0) ? 4'hF : a1;
        d1 = (s1 == 4'd0) ? 4'hF : s1;
`else
        d3 = a1;
        d1 = s1;
`endif
    end

endmodule

// File: tb/tb_score_bcd_keeper.sv
// tb/tb_score_bcd_keeper.sv - scoreboard bench for score_bcd_keeper
module tb_score_bcd_keeper;

    localparam int CLK_HZ  = 40;
    localparam int SCAN_HZ = 4;
    localparam int DIV     = CLK_HZ / SCAN_HZ;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       add_valid;
    logic [1:0] add_pts;
    logic       add_ready;
    logic       clear;
    logic       scan_en;
    logic [3:0] d3, d2, d1, d0;
    logic       busy;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] d3, d2, d1, d0;
        logic       busy, ovf, ready, scan;
    } exp_t;

    exp_t q[$];

    int  m_score, m_att, m_pend, cyc;
    bit  m_ovf;
    bit  done = 0;

    score_bcd_keeper #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ)) dut (
        .clk(clk), .rst_n(rst_n), .add_valid(add_valid), .add_pts(add_pts),
        .add_ready(add_ready), .clear(clear), .scan_en(scan_en),
        .d3(d3), .d2(d2), .d1(d1), .d0(d0), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] tens(input int v);
        int t;
        t = v / 10;
`ifdef SCORE_BLANK_EN
        if (t == 0) return 4'hF;
`endif
        return 4'(t);
    endfunction

    // One clock cycle: apply inputs, record what the DUT must show now, advance the model
    task automatic step(input logic v, input logic [1:0] p, input logic c);
        exp_t e;
        add_valid = v;
        add_pts   = p;
        clear     = c;
        e.d3    = tens(m_att);
        e.d2    = 4'(m_att % 10);
        e.d1    = tens(m_score);
        e.d0    = 4'(m_score % 10);
        e.busy  = (m_pend > 0);
        e.ovf   = m_ovf;
        e.ready = (m_pend == 0) && !c;
        e.scan  = ((cyc % DIV) == DIV - 1);
        q.push_back(e);
        if (c) begin
            m_score = 0; m_att = 0; m_pend = 0; m_ovf = 0;
        end else if (m_pend > 0) begin
            if (m_score < 99) m_score++;
            else m_ovf = 1;
            m_pend--;
        end else if (v) begin
            if (m_att < 99) m_att++;
            m_pend = int'(p);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic shot(input logic [1:0] p);
        step(1'b1, p, 1'b0);
        while (m_pend > 0) step(1'b0, 2'd0, 1'b0);
    endtask

    // Monitor: compares every DUT cycle against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("d3", d3, e.d3);
                chk("d2", d2, e.d2);
                chk("d1", d1, e.d1);
                chk("d0", d0, e.d0);
                chk("busy", busy, e.busy);
                chk("overflow", overflow, e.ovf);
                chk("add_ready", add_ready, e.ready);
                chk("scan_en", scan_en, e.scan);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; add_valid = 1'b0; add_pts = 2'd0; clear = 1'b0;
        m_score = 0; m_att = 0; m_pend = 0; m_ovf = 0; cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_digits", {d3, d2, d1, d0}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_scan_en", scan_en, 0);
        rst_n = 1'b1;

        shot(2'd2);
        repeat (3) step(1'b0, 2'd0, 1'b0);

        step(1'b0, 2'd0, 1'b1);
        repeat (3) shot(2'd3);
        repeat (6) shot(2'd0);
        shot(2'd1);

        repeat (29) shot(2'd3);
        shot(2'd1);
        shot(2'd3);
        shot(2'd2);
        repeat (62) step(1'b1, 2'd0, 1'b0);

        step(1'b1, 2'd3, 1'b0);
        step(1'b1, 2'd2, 1'b1);
        step(1'b0, 2'd0, 1'b0);

        repeat (4) step(1'b1, 2'd0, 1'b0);
        step(1'b0, 2'd0, 1'b0);

        shot(2'd3);
        shot(2'd2);
        repeat (3) step(1'b0, 2'd0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 49) == 0));
        end
        step(1'b0, 2'd0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
